sda_cmd_tx: RTL and testbench



---
 rtl/sda_cmd_tx_pkg.sv | 20 ++
 rtl/sda_cmd_tx_cmd_queue.sv | 76 +++++++
 rtl/sda_cmd_tx.sv | 179 +++++++++++++++++
 tb/tb_sda_cmd_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sda_cmd_tx_pkg.sv
// sda_cmd_tx_pkg
// Shared definitions for the SCK/SDA command transmitter: frame and field
// widths, counter widths and the transmit FSM state encoding.
package sda_cmd_tx_pkg;

    localparam int FRAME_W   = 24;
    localparam int CMD_W     = 8;
    localparam int DATA_W    = 16;
    localparam int CNT_W     = 8;
    localparam int BIT_CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOW,
        ST_HIGH,
        ST_GAP
    } txState_e;

endpackage

// File: rtl/sda_cmd_tx_cmd_queue.sv
// cmd_queue
// Synchronous FIFO holding pending {command, data} frames for the
// transmitter. Pointers carry one extra wrap bit so full and empty can be
// told apart when the index bits match.
//
// Ports:
//   MCI        main clock, rising edge
//   ClrW       asynchronous active-high reset, empties the queue
//   wrEn_i     push wrData_i (ignored while full_o)
//   wrData_i   entry to store
//   rdEn_i     pop the head entry (ignored while empty_o)
//   rdData_o   current head entry
//   full_o     DEPTH entries held
//   empty_o    no entries held
module cmd_queue
    import sda_cmd_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FRAME_W
) (
    input  logic             MCI,
    input  logic             ClrW,
    input  logic             wrEn_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic             rdEn_i,
    output logic [WIDTH-1:0] rdData_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic             push;
    logic             pop;

    // Full is judged on the registered pointers, so a write arriving while
    // full is dropped even if a pop happens on the same edge.
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign push    = wrEn_i && !full_o;
    assign pop     = rdEn_i && !empty_o;

    assign rdData_o = mem[rdPtr_q[AW-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    always_ff @(posedge MCI or posedge ClrW) begin
        if (ClrW) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge MCI) begin
        if (push) begin
            mem[wrPtr_q[AW-1:0]] <= wrData_i;
        end
    end

endmodule

// File: rtl/sda_cmd_tx.sv
// sda_cmd_tx
// Serial command transmitter. Parallel (Cmd, Data) writes are queued and each
// is sent as a 24-bit MSB-first frame on SCK/SDA, with SCK half-period of
// CLK_DIV MCI cycles and GAP_CYC idle cycles after every frame.
//
// Ports:
//   MCI    main clock, rising edge
//   ClrW   asynchronous active-high reset, aborts any frame in flight
//   Wr     write strobe, pushes {Cmd, Data} when Full is low
//   Cmd    register select, frame bits 23:16
//   Data   register value, frame bits 15:0
//   Full   queue holds DEPTH entries
//   Busy   frame in progress (shift or gap)
//   Done   one-cycle pulse in the last gap cycle of each frame
//   SCK    serial clock, idle low
//   SDA    serial data, changes only while SCK is low
module sda_cmd_tx
    import sda_cmd_tx_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 8,
    parameter int DEPTH   = 4
) (
    input  logic              MCI,
    input  logic              ClrW,
    input  logic              Wr,
    input  logic [CMD_W-1:0]  Cmd,
    input  logic [DATA_W-1:0] Data,
    output logic              Full,
    output logic              Busy,
    output logic              Done,
    output logic              SCK,
    output logic              SDA
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    txState_e               state_q, state_d;
    logic [CNT_W-1:0]       divCnt_q, divCnt_d;
    logic [BIT_CNT_W-1:0]   bitCnt_q, bitCnt_d;
    logic [FRAME_W-1:0]     shift_q, shift_d;
    logic                   sck_q, sck_d;
    logic                   sda_q, sda_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   pop;
    logic                   qEmpty;
    logic                   qFull;
    logic [FRAME_W-1:0]     qHead;

    cmd_queue #(
        .DEPTH (DEPTH),
        .WIDTH (FRAME_W)
    ) u_queue (
        .MCI      (MCI),
        .ClrW     (ClrW),
        .wrEn_i   (Wr),
        .wrData_i ({Cmd, Data}),
        .rdEn_i   (pop),
        .rdData_o (qHead),
        .full_o   (qFull),
        .empty_o  (qEmpty)
    );

    // One divider counter serves both SCK half-periods and the inter-frame
    // gap; it is cleared on every state change so each phase starts at zero.
    // The shift register's MSB is always the bit on SDA, so the next bit to
    // present is shift_q[FRAME_W-2].
    always_comb begin
        state_d  = state_q;
        divCnt_d = divCnt_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        sck_d    = sck_q;
        sda_d    = sda_q;
        busy_d   = busy_q;
        pop      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!qEmpty) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                pop      = 1'b1;
                shift_d  = qHead;
                bitCnt_d = BIT_CNT_W'(FRAME_W - 1);
                sda_d    = qHead[FRAME_W-1];
                sck_d    = 1'b0;
                busy_d   = 1'b1;
                divCnt_d = '0;
                state_d  = ST_LOW;
            end

            ST_LOW: begin
                if (divCnt_q == DIV_LAST) begin
                    divCnt_d = '0;
                    sck_d    = 1'b1;
                    state_d  = ST_HIGH;
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end
            end

            ST_HIGH: begin
                if (divCnt_q == DIV_LAST) begin
                    divCnt_d = '0;
                    sck_d    = 1'b0;
                    if (bitCnt_q == '0) begin
                        sda_d   = 1'b0;
                        state_d = ST_GAP;
                    end else begin
                        shift_d  = {shift_q[FRAME_W-2:0], 1'b0};
                        sda_d    = shift_q[FRAME_W-2];
                        bitCnt_d = bitCnt_q - 1'b1;
                        state_d  = ST_LOW;
                    end
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end
            end

            ST_GAP: begin
                if (divCnt_q == GAP_LAST) begin
                    divCnt_d = '0;
                    if (!qEmpty) begin
                        state_d = ST_LOAD;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Done is registered, so it is raised on the edge that begins the
        // final gap cycle; with a one-cycle gap that is the entry edge.
        done_d = (state_d == ST_GAP) && (divCnt_d == GAP_LAST);
    end

    always_ff @(posedge MCI or posedge ClrW) begin
        if (ClrW) begin
            state_q  <= ST_IDLE;
            divCnt_q <= '0;
            bitCnt_q <= '0;
            shift_q  <= '0;
            sck_q    <= 1'b0;
            sda_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            divCnt_q <= divCnt_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            sck_q    <= sck_d;
            sda_q    <= sda_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Full = qFull;
    assign Busy = busy_q;
    assign Done = done_q;
    assign SCK  = sck_q;
    assign SDA  = sda_q;

endmodule

// File: tb/tb_sda_cmd_tx.sv
// tb_sda_cmd_tx
// Drives two transmitters (CLK_DIV=4/GAP_CYC=8 and CLK_DIV=1/GAP_CYC=1) with
// the same write stream. Each lane keeps a transaction-level model of the
// queue and frame timing; expected frames go into a scoreboard queue that a
// negedge monitor pops whenever 24 SCK rises have been collected.
module tb_sda_cmd_tx;

    localparam int DEPTH = 4;

    logic        MCI  = 1'b0;
    logic        ClrW = 1'b1;
    logic        Wr   = 1'b0;
    logic [7:0]  Cmd  = '0;
    logic [15:0] Data = '0;

    int assertCount = 0;
    int failCount   = 0;

    always #5 MCI = ~MCI;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int CD = (g == 0) ? 4 : 1;
        localparam int GC = (g == 0) ? 8 : 1;

        logic full, busy, done, sck, sda;

        sda_cmd_tx #(
            .CLK_DIV (CD),
            .GAP_CYC (GC),
            .DEPTH   (DEPTH)
        ) dut (
            .MCI  (MCI),
            .ClrW (ClrW),
            .Wr   (Wr),
            .Cmd  (Cmd),
            .Data (Data),
            .Full (full),
            .Busy (busy),
            .Done (done),
            .SCK  (sck),
            .SDA  (sda)
        );

        // Reference model: a frame is popped one edge after the engine decides
        // to start it; it then lasts 48*CD + GC cycles, and the decision for
        // the next frame is taken on the edge that ends the gap. An idle
        // engine decides on every edge, based on the queue before that edge.
        logic [23:0] q[$];
        logic [23:0] expFrames[$];
        logic [23:0] curFrame;
        int          cyc, popEdge, decEdge, curPop;
        bit          engaged, haveFrame, busyM, fullPre, emptyPre;

        always @(posedge MCI or posedge ClrW) begin
            if (ClrW) begin
                q.delete();
                expFrames.delete();
                cyc       = 0;
                popEdge   = -1;
                decEdge   = -1;
                curPop    = 0;
                engaged   = 0;
                haveFrame = 0;
                busyM     = 0;
            end else begin
                cyc++;
                fullPre  = (q.size() == DEPTH);
                emptyPre = (q.size() == 0);
                if (engaged && cyc == decEdge) begin
                    if (!emptyPre) begin
                        popEdge = cyc + 1;
                    end else begin
                        engaged = 0;
                        busyM   = 0;
                    end
                end else if (!engaged && !emptyPre) begin
                    engaged = 1;
                    popEdge = cyc + 1;
                end
                if (cyc == popEdge) begin
                    curFrame  = q.pop_front();
                    curPop    = cyc;
                    haveFrame = 1;
                    busyM     = 1;
                    decEdge   = cyc + 48 * CD + GC;
                    expFrames.push_back(curFrame);
                end
                if (Wr && !fullPre) begin
                    q.push_back({Cmd, Data});
                end
            end
        end

        // Monitor: per-cycle pin comparison plus frame reassembly on SCK rises.
        logic [23:0] bits;
        int          nb = 0;
        int          t;
        logic        prevSck = 1'b0;
        logic        expSck, expSda, expDone;

        always @(negedge MCI) begin
            if (ClrW) begin
                nb = 0;
            end else begin
                t       = cyc - curPop;
                expSck  = 1'b0;
                expSda  = 1'b0;
                if (haveFrame && t < 48 * CD) begin
                    expSck = ((t / CD) % 2) == 1;
                    expSda = curFrame[23 - t / (2 * CD)];
                end
                expDone = haveFrame && (cyc == decEdge - 1);
                checkOutput($sformatf("lane%0d.SCK", g), 32'(sck), 32'(expSck));
                checkOutput($sformatf("lane%0d.SDA", g), 32'(sda), 32'(expSda));
                checkOutput($sformatf("lane%0d.Busy", g), 32'(busy), 32'(busyM));
                checkOutput($sformatf("lane%0d.Done", g), 32'(done), 32'(expDone));
                checkOutput($sformatf("lane%0d.Full", g), 32'(full), 32'(q.size() == DEPTH));
                if (sck && !prevSck) begin
                    bits = {bits[22:0], sda};
                    nb++;
                    if (nb == 24) begin
                        nb = 0;
                        if (expFrames.size() == 0) begin
                            checkOutput($sformatf("lane%0d.frame_expected", g), 32'(expFrames.size()), 32'd1);
                        end else begin
                            checkOutput($sformatf("lane%0d.frame", g), 32'(bits), 32'(expFrames.pop_front()));
                        end
                    end
                end
            end
            prevSck = sck;
        end
    end

    // One cycle of stimulus: values change 2 time units after the rising edge
    // and are sampled on the following rising edge.
    task automatic applyStimulus(input bit w, input logic [7:0] c, input logic [15:0] d);
        @(posedge MCI);
        #2;
        Wr   = w;
        Cmd  = c;
        Data = d;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, 16'h0000);
        end
    endtask

    task automatic checkAllLow();
        checkOutput("rst.lane0.SCK", 32'(lane[0].sck), 32'd0);
        checkOutput("rst.lane0.SDA", 32'(lane[0].sda), 32'd0);
        checkOutput("rst.lane0.Busy", 32'(lane[0].busy), 32'd0);
        checkOutput("rst.lane0.Done", 32'(lane[0].done), 32'd0);
        checkOutput("rst.lane0.Full", 32'(lane[0].full), 32'd0);
        checkOutput("rst.lane1.SCK", 32'(lane[1].sck), 32'd0);
        checkOutput("rst.lane1.SDA", 32'(lane[1].sda), 32'd0);
        checkOutput("rst.lane1.Busy", 32'(lane[1].busy), 32'd0);
        checkOutput("rst.lane1.Done", 32'(lane[1].done), 32'd0);
        checkOutput("rst.lane1.Full", 32'(lane[1].full), 32'd0);
    endtask

    initial begin
        int budget;

        repeat (3) @(posedge MCI);
        #1;
        checkAllLow();
        #1;
        ClrW = 1'b0;

        $display("[TB] single frames");
        applyStimulus(1'b1, 8'h05, 16'h1234);
        idleCycles(260);
        applyStimulus(1'b1, 8'h00, 16'hFFFF);
        idleCycles(260);

        $display("[TB] overflow burst");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(i), 16'($urandom));
        end
        idleCycles(1100);

        $display("[TB] sustained write pressure");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'b1, 8'(i), 16'($urandom));
        end
        idleCycles(1100);

        $display("[TB] random writes");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 39) == 0, 8'($urandom), 16'($urandom));
        end
        idleCycles(1100);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'hC0 + 8'(i), 16'($urandom));
        end
        budget = 500;
        while (!(lane[0].haveFrame && (lane[0].cyc - lane[0].curPop) >= 19 * 4 + 1) && budget > 0) begin
            applyStimulus(1'b0, 8'h00, 16'h0000);
            budget--;
        end
        checkOutput("reset_wait_budget", 32'(budget > 0), 32'd1);
        #1;
        ClrW = 1'b1;
        #1;
        checkAllLow();
        repeat (2) @(posedge MCI);
        #2;
        ClrW = 1'b0;
        applyStimulus(1'b1, 8'h3C, 16'hBEEF);
        idleCycles(260);

        checkOutput("lane0.frames_outstanding", 32'(lane[0].expFrames.size()), 32'd0);
        checkOutput("lane1.frames_outstanding", 32'(lane[1].expFrames.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
